// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - MSB-first accumulator turning per-bit compare flags into a word result
module serial_mag_comparator #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic in_aeb,
  input  logic in_alb,
  input  logic in_agb,
  output logic busy,
  output logic done,
  output logic aeb,
  output logic alb,
  output logic agb,
  output logic err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {DEC_EQ, DEC_LT, DEC_GT} dec_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state, state_n;
  dec_t           decision, dec_n;
  logic [CW-1:0]  count;
  logic [2:0]     flags;
  logic           one_hot;
  logic           last_beat;

  assign flags     = {in_aeb, in_alb, in_agb};
  assign one_hot   = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  assign last_beat = in_valid && (count == LAST);

  // Only the first non-equal beat may move the decision away from EQ.
  always_comb begin
    dec_n = decision;
    if (decision == DEC_EQ) begin
      if (flags == 3'b010)      dec_n = DEC_LT;
      else if (flags == 3'b001) dec_n = DEC_GT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last_beat) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      decision <= DEC_EQ;
      aeb      <= 1'b0;
      alb      <= 1'b0;
      agb      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count    <= '0;
            decision <= DEC_EQ;
            aeb      <= 1'b0;
            alb      <= 1'b0;
            agb      <= 1'b0;
            err      <= 1'b0;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (!one_hot) err <= 1'b1;
            decision <= dec_n;
            if (last_beat) begin
              count <= '0;
              aeb   <= (dec_n == DEC_EQ);
              alb   <= (dec_n == DEC_LT);
              agb   <= (dec_n == DEC_GT);
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - directed table-driven bench for serial_mag_comparator
module tb_serial_mag_comparator;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_aeb, in_alb, in_agb;
  logic busy, done, aeb, alb, agb, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_aeb(in_aeb), .in_alb(in_alb), .in_agb(in_agb),
    .busy(busy), .done(done), .aeb(aeb), .alb(alb), .agb(agb), .err(err)
  );

  typedef struct {
    string       name;
    logic [23:0] beats;      // beat 1 in [23:21], flags {aeb,alb,agb}
    logic [15:0] gaps;       // idle cycles before beat i in [15-2i -: 2]
    int          start_beat; // beat index carrying a (to-be-ignored) start, -1 none
    logic [2:0]  res;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic start_cmp(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, " start busy"}, busy, 1);
    chk({name, " start clear"}, {done, aeb, alb, agb, err}, 0);
  endtask

  // Entered at a negedge with the DUT in RUN; leaves it after the DONE cycle.
  task automatic feed(input vec_t v, input bit chain);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < int'(v.gaps[15-2*i -: 2]); g++) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk({v.name, " gap"}, {busy, done}, 2'b10);
      end
      in_valid = 1'b1;
      {in_aeb, in_alb, in_agb} = v.beats[23-3*i -: 3];
      start = (i == v.start_beat);
      @(negedge clk);
      in_valid = 1'b0;
      start = 1'b0;
      if (i < 7) chk({v.name, " running"}, {busy, done}, 2'b10);
    end
    chk({v.name, " done pulse"}, {busy, done}, 2'b01);
    chk({v.name, " result"}, {aeb, alb, agb}, v.res);
    chk({v.name, " err"}, err, v.err);
    if (chain) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({v.name, " restart"}, {busy, done, aeb, alb, agb, err}, 6'b100000);
    end else begin
      @(negedge clk);
      chk({v.name, " after done"}, {busy, done}, 2'b00);
      chk({v.name, " hold"}, {aeb, alb, agb, err}, {v.res, v.err});
    end
  endtask

  initial begin
    vecs[0] = '{"eq_a5", {8{3'b100}}, 16'h0, -1, 3'b100, 1'b0};
    vecs[1] = '{"gt_80_7f", {3'b001, {7{3'b010}}}, 16'h0, -1, 3'b001, 1'b0};
    vecs[2] = '{"lt_12_13_gaps", {{7{3'b100}}, 3'b010}, 16'b01_10_11_01_10_11_01_10, -1, 3'b010, 1'b0};
    vecs[3] = '{"bad_beat3", {3'b100, 3'b100, 3'b110, 3'b010, 3'b001, 3'b100, 3'b100, 3'b100},
                16'h0, 4, 3'b010, 1'b1};
    vecs[4] = '{"gt_last", {{7{3'b100}}, 3'b001}, 16'b00_00_01_00_00_00_00_01, -1, 3'b001, 1'b0};
    vecs[5] = '{"eq_bad_last", {{6{3'b100}}, 3'b000, 3'b111}, 16'h0, 1, 3'b100, 1'b1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    {in_aeb, in_alb, in_agb} = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("reset outputs", {busy, done, aeb, alb, agb, err}, 0);
    rst = 1'b0;

    in_valid = 1'b1;
    {in_aeb, in_alb, in_agb} = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle ignores valid", {busy, done}, 0);
    end
    in_valid = 1'b0;

    for (int k = 0; k < 6; k++) begin
      start_cmp(vecs[k].name);
      feed(vecs[k], 1'b0);
    end

    // Reset after beat 4 aborts the comparison immediately.
    start_cmp("abort");
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      {in_aeb, in_alb, in_agb} = (i == 0) ? 3'b001 : 3'b111;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort async clear", {busy, done, aeb, alb, agb, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        seen = seen | done | busy;
      end
      chk("abort no done", seen, 0);
    end
    start_cmp("post_reset");
    feed(vecs[1], 1'b0);

    // Start in the DONE cycle restarts directly into RUN.
    start_cmp("chain");
    feed(vecs[3], 1'b1);
    feed(vecs[2], 1'b1);
    feed(vecs[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
